serial_adder_ctrl: RTL and testbench

Bit-serial addition controller that sequences a single 1-bit full-adder cell over WIDTH clock cycles to add two WIDTH-bit operands, LSB first. It sits between a requester using a start/done handshake and the shared full-adder datapath cell. It owns the operand shift registers, the carry flip-flop, the bit counter and the control FSM.

---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/serial_adder_ctrl_if.sv | 28 ++
 rtl/serial_adder_ctrl_full_adder.sv | 13 +
 rtl/serial_adder_ctrl.sv | 119 +++++++++++
 tb/tb_serial_adder_ctrl.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Requester-side bundle: start/done handshake, operands and result.
interface serial_adder_ctrl_if
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, ovf
  );

endinterface

// File: rtl/serial_adder_ctrl_full_adder.sv
// Single-bit combinational full-adder cell shared by the serial datapath.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: sequences one full-adder cell over WIDTH cycles, LSB first,
// with a start/done handshake and back-to-back restart from DONE.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic              clk,
  input  logic              reset_n,
  serial_adder_ctrl_if.slave bus
);

  localparam int                CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q,  a_sh_d;
  logic [WIDTH-1:0]   b_sh_q,  b_sh_d;
  logic [WIDTH-1:0]   sum_q,   sum_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic               carry_q, carry_d;
  logic               cout_q,  cout_d;
  logic               ovf_q,   ovf_d;

  logic               accept;
  logic               fa_s;
  logic               fa_co;
  logic               c_msb;

  full_adder u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_co)
  );

  // Carry entering the MSB position is the carry register during the last RUN bit.
  assign c_msb = carry_q;

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    accept  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
        sum_d   = {fa_s, sum_q[WIDTH-1:1]};
        carry_d = fa_co;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          cout_d  = fa_co;
          ovf_d   = c_msb ^ fa_co;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Capture leaves sum/cout/ovf untouched so the previous result stays visible until RUN.
    if (accept) begin
      a_sh_d  = bus.a;
      b_sh_d  = bus.b;
      carry_d = bus.cin;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: vector table plus ignored-start, back-to-back and mid-RUN reset sequences.
module tb_serial_adder_ctrl;
  import serial_adder_pkg::*;

  localparam int W       = 8;
  localparam int TIMEOUT = 40;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_ovf;
  } vec_t;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   checks  = 0;
  int   errors  = 0;
  int   overlap = 0;

  serial_adder_ctrl_if #(.WIDTH(W)) bus ();

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Counts cycles (sampled 1ns after each edge) until done is seen, bounded by TIMEOUT.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!bus.done && cyc < TIMEOUT) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.busy && bus.done) overlap++;
    end
  endtask

  task automatic run_op(input vec_t v, input string tag);
    int cyc;
    @(posedge clk);
    #1;
    bus.a     = v.a;
    bus.b     = v.b;
    bus.cin   = v.cin;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check({tag, "_busy"}, bus.busy, 1'b1);
    wait_done(cyc);
    check({tag, "_latency"}, cyc, W);
    check({tag, "_sum"},  bus.sum,  v.exp_sum);
    check({tag, "_cout"}, bus.cout, v.exp_cout);
    check({tag, "_ovf"},  bus.ovf,  v.exp_ovf);
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, {bus.busy, bus.done}, 2'b00);
    check({tag, "_sum_hold"}, bus.sum, v.exp_sum);
  endtask

  initial begin
    vec_t vecs[8];
    vec_t v;
    int   cyc;
    int   done_seen;

    vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h3C, 8'h0F, 1'b1, 8'h4C, 1'b0, 1'b0};
    vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[5] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[6] = '{8'h64, 8'h64, 1'b0, 8'hC8, 1'b0, 1'b1};
    vecs[7] = '{8'hC0, 8'hC0, 1'b0, 8'h80, 1'b1, 1'b0};

    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {bus.busy, bus.done, bus.sum, bus.cout, bus.ovf}, '0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
    end

    // 0x12+0x34 with a stray start during RUN cycle 3.
    @(posedge clk);
    #1;
    bus.a = 8'h12; bus.b = 8'h34; bus.cin = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    bus.a = 8'hFF; bus.b = 8'hFF; bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(cyc);
    check("ign_latency", cyc + 3, W);
    check("ign_sum",  bus.sum,  8'h46);
    check("ign_cout", bus.cout, 1'b0);
    check("ign_ovf",  bus.ovf,  1'b0);

    // Back-to-back: start held in DONE with 0x01+0x01.
    bus.a = 8'h01; bus.b = 8'h01; bus.cin = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    #1;
    check("b2b_no_idle", {bus.busy, bus.done}, 2'b10);
    check("b2b_sum_held", bus.sum, 8'h46);
    bus.start = 1'b0;
    wait_done(cyc);
    check("b2b_latency", cyc, W);
    check("b2b_sum",  bus.sum,  8'h02);
    check("b2b_cout", bus.cout, 1'b0);
    check("b2b_ovf",  bus.ovf,  1'b0);

    // Leave nonzero cout/ovf/sum so the reset clearing is observable.
    v = '{8'h80, 8'hC0, 1'b0, 8'h40, 1'b1, 1'b1};
    run_op(v, "pre_rst");

    @(posedge clk);
    #1;
    bus.a = 8'h55; bus.b = 8'h0F; bus.cin = 1'b1; bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("mid_run_busy", bus.busy, 1'b1);
    reset_n = 1'b0;
    #1;
    check("mid_run_reset", {bus.busy, bus.done, bus.sum, bus.cout, bus.ovf}, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) done_seen++;
    end
    check("no_done_after_abort", done_seen, 0);

    v = '{8'h21, 8'h13, 1'b0, 8'h34, 1'b0, 1'b0};
    run_op(v, "post_rst");

    check("busy_done_overlap", overlap, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
